// File: rtl/id_inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue.
// Entries are packed {pc, inst} so they line up with the if_to_id_bus layout.
`ifndef ID_Q_PACK
`define ID_Q_PACK(pc, inst) {pc, inst}
`endif

package id_inst_queue_pkg;
    localparam int ID_Q_DEPTH    = 4;
    localparam int ID_Q_PC_W     = 32;
    localparam int ID_Q_INST_W   = 32;
    localparam int ID_Q_ENTRY_WD = ID_Q_PC_W + ID_Q_INST_W;

    function automatic int id_q_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/id_inst_queue_mem.sv
// Storage array for the instruction queue: one write port, one async read port.
// Data is not reset; validity is tracked by the control logic.
module inst_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WD    = 64
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WD-1:0]            wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WD-1:0]            rd_data_o
);
    logic [WD-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: captures SRAM responses while ID stalls,
// bypasses straight through when empty, and drops everything on a branch flush.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int DEPTH  = ID_Q_DEPTH,
    parameter int PC_W   = ID_Q_PC_W,
    parameter int INST_W = ID_Q_INST_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [PC_W-1:0]              req_pc,
    output logic                         req_ready,
    input  logic [INST_W-1:0]            inst_sram_rdata,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [PC_W-1:0]              out_pc,
    output logic [INST_W-1:0]            out_inst,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = id_q_cnt_w(DEPTH);
    localparam int ENTRY_WD = PC_W + INST_W;

    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                inflight_q, inflight_d;
    logic [PC_W-1:0]     inflight_pc_q, inflight_pc_d;

    logic                kill, empty, resp_valid, pop, pop_stored, write, accept;
    logic [ENTRY_WD-1:0] head_entry, resp_entry;

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .WD    (ENTRY_WD)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (write),
        .wr_addr_i (tail_q),
        .wr_data_i (resp_entry),
        .rd_addr_i (head_q),
        .rd_data_o (head_entry)
    );

    // A reset cycle discards the in-flight response the same way a flush does.
    always_comb begin
        kill       = rst | flush;
        empty      = (count_q == '0);
        resp_valid = inflight_q & ~kill;
        resp_entry = `ID_Q_PACK(inflight_pc_q, inst_sram_rdata);

        out_valid = ~kill & (~empty | resp_valid);
        if (!empty) begin
            {out_pc, out_inst} = head_entry;
        end else if (resp_valid) begin
            {out_pc, out_inst} = resp_entry;
        end else begin
            {out_pc, out_inst} = '0;
        end

        pop        = out_valid & out_ready;
        pop_stored = pop & ~empty;
        write      = resp_valid & ~(empty & pop);

        // Pops are not credited, so a granted fetch always has a free slot.
        req_ready = ~kill &
                    (({1'b0, count_q} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH));
        accept    = req_valid & req_ready;
    end

    always_comb begin
        head_d        = head_q + PTR_W'(pop_stored);
        tail_d        = tail_q + PTR_W'(write);
        count_d       = count_q + CNT_W'(write) - CNT_W'(pop_stored);
        inflight_d    = accept;
        inflight_pc_d = accept ? req_pc : inflight_pc_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign occupancy = count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(write && count_q == CNT_W'(DEPTH)));
        end
    end
endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_id_inst_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        req_ready;
    logic [31:0] inst_sram_rdata = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_pc          (req_pc),
        .req_ready       (req_ready),
        .inst_sram_rdata (inst_sram_rdata),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_ready       (out_ready),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: stored pcs in FIFO order plus the one outstanding fetch
    logic [31:0] mq[$];
    logic        m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic        lr_v = 1'b0;
    logic [31:0] lr_pc = '0;
    logic        e_kill, e_resp, e_ready, e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic [31:0] acc_log[$];
    logic [31:0] dlv_log[$];

    function automatic logic [31:0] mkinst(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive(input logic rv, input logic [31:0] pc, input logic fl,
                         input logic ordy, input logic r);
        @(negedge clk);
        rst       = r;
        req_valid = rv;
        req_pc    = pc;
        flush     = fl;
        out_ready = ordy;
        inst_sram_rdata = lr_v ? mkinst(lr_pc) : $urandom;
        #1;
        e_kill  = r | fl;
        e_resp  = m_infl & ~e_kill;
        e_ready = ~e_kill && (mq.size() + int'(m_infl) < DEPTH);
        e_valid = ~e_kill && (mq.size() != 0 || e_resp);
        e_pc    = (mq.size() != 0) ? mq[0] : (e_resp ? m_infl_pc : 32'h0);
        e_occ   = 3'(mq.size());
    endtask

    task automatic step();
        logic was_empty;
        logic pop;
        was_empty = (mq.size() == 0);
        pop = e_valid & out_ready;
        if (out_valid && out_ready) dlv_log.push_back(out_pc);
        if (rst || flush) begin
            mq.delete();
            m_infl = 1'b0;
        end else begin
            if (pop && !was_empty) void'(mq.pop_front());
            if (e_resp && !(was_empty && pop)) mq.push_back(m_infl_pc);
            m_infl = req_valid & e_ready;
            if (m_infl) begin
                m_infl_pc = req_pc;
                acc_log.push_back(req_pc);
            end
        end
        lr_v  = req_valid;
        lr_pc = req_pc;
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(0, 32'h0, 0, 0, 1);
        step();
        drive(1, 32'h0, 0, 1, 1);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin fails++; $display("FAIL rst_out_data: got %h/%h want 0/0", out_pc, out_inst); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        step();
        drive(0, 32'h0, 0, 1, 0);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_rst_valid: got %b want 0", out_valid); end
        step();
    endtask

    task automatic test_bypass();
        logic [31:0] pc;
        for (int i = 0; i < 5; i++) begin
            pc = 32'hBFC0_0000 + 32'(4 * i);
            drive(i < 4, pc, 0, 1, 0);
            if (i > 0) begin
                tests++; if (out_valid !== 1'b1 || out_pc !== pc - 32'h4) begin fails++; $display("FAIL bypass_pc[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_pc, pc - 32'h4); end
                tests++; if (out_inst !== mkinst(pc - 32'h4)) begin fails++; $display("FAIL bypass_inst[%0d]: got %h want %h", i, out_inst, mkinst(pc - 32'h4)); end
            end
            tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL bypass_occ[%0d]: got %0d want 0", i, occupancy); end
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bypass_ready[%0d]: got %b want 1", i, req_ready); end
            step();
        end
    endtask

    task automatic test_stall_fill();
        int n_acc;
        n_acc = 0;
        acc_log.delete();
        dlv_log.delete();
        for (int k = 0; k < 7; k++) begin
            drive(1, 32'h1000 + 32'(4 * k), 0, 0, 0);
            tests++; if (req_ready !== e_ready) begin fails++; $display("FAIL fill_ready[%0d]: got %b want %b", k, req_ready, e_ready); end
            tests++; if (occupancy !== e_occ) begin fails++; $display("FAIL fill_occ[%0d]: got %0d want %0d", k, occupancy, e_occ); end
            if (req_ready === 1'b1) n_acc++;
            step();
        end
        drive(0, 32'h0, 0, 0, 0);
        tests++; if (n_acc != DEPTH) begin fails++; $display("FAIL fill_accepts: got %0d want %0d", n_acc, DEPTH); end
        tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL fill_full_occ: got %0d want 4", occupancy); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready: got %b want 0", req_ready); end
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h1000) begin fails++; $display("FAIL fill_head: got v=%b %h want v=1 00001000", out_valid, out_pc); end
        step();
    endtask

    task automatic test_drain_wrap();
        int bad;
        for (int k = 0; k < 18; k++) begin
            drive(k < 10, 32'h2000 + 32'(4 * k), 0, 1, 0);
            tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL drain_valid[%0d]: got %b want %b", k, out_valid, e_valid); end
            if (e_valid) begin
                tests++; if (out_pc !== e_pc || out_inst !== mkinst(e_pc)) begin fails++; $display("FAIL drain_data[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, e_pc, mkinst(e_pc)); end
            end
            step();
        end
        tests++; if (dlv_log.size() != acc_log.size()) begin fails++; $display("FAIL drain_count: got %0d want %0d", dlv_log.size(), acc_log.size()); end
        bad = 0;
        for (int i = 0; i < acc_log.size() && i < dlv_log.size(); i++)
            if (dlv_log[i] !== acc_log[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL drain_order: got %0d misordered want 0", bad); end
        drive(0, 32'h0, 0, 1, 0);
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got occ=%0d v=%b want 0/0", occupancy, out_valid); end
        step();
    endtask

    task automatic test_flush();
        drive(1, 32'h3000, 0, 0, 0); step();
        drive(1, 32'h3004, 0, 0, 0); step();
        drive(1, 32'h3008, 0, 0, 0); step();
        drive(1, 32'h300C, 1, 0, 0);
        tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        step();
        drive(1, 32'h3100, 0, 1, 0);
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_post_occ: got %0d want 0", occupancy); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_inflight_dropped: got v=%b pc=%h want v=0", out_valid, out_pc); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL flush_post_ready: got %b want 1", req_ready); end
        step();
        drive(0, 32'h0, 0, 1, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h3100 || out_inst !== mkinst(32'h3100)) begin fails++; $display("FAIL flush_redirect: got v=%b %h/%h want v=1 00003100/%h", out_valid, out_pc, out_inst, mkinst(32'h3100)); end
        step();
    endtask

    task automatic test_simul_wr_pop();
        drive(1, 32'h4000, 0, 0, 0); step();
        drive(1, 32'h4004, 0, 0, 0); step();
        drive(0, 32'h0, 0, 1, 0);
        tests++; if (occupancy !== 3'd1 || out_pc !== 32'h4000) begin fails++; $display("FAIL wrpop_pre: got occ=%0d pc=%h want 1/00004000", occupancy, out_pc); end
        step();
        drive(0, 32'h0, 0, 0, 0);
        tests++; if (occupancy !== 3'd1) begin fails++; $display("FAIL wrpop_occ: got %0d want 1", occupancy); end
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h4004 || out_inst !== mkinst(32'h4004)) begin fails++; $display("FAIL wrpop_head: got v=%b %h/%h want v=1 00004004/%h", out_valid, out_pc, out_inst, mkinst(32'h4004)); end
        step();
        drive(0, 32'h0, 0, 1, 0); step();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h5000 + 32'(4 * k), 0, 0, 0);
            step();
        end
        drive(0, 32'h0, 0, 0, 1);
        tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL rstmid_pre_occ: got %0d want 3", occupancy); end
        step();
        drive(1, 32'h100, 0, 1, 0);
        tests++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin fails++; $display("FAIL rstmid_out: got v=%b %h/%h want 0", out_valid, out_pc, out_inst); end
        tests++; if (occupancy !== 3'd0 || req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state: got occ=%0d rdy=%b want 0/1", occupancy, req_ready); end
        step();
        drive(0, 32'h0, 0, 1, 0);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== mkinst(32'h100)) begin fails++; $display("FAIL rstmid_bypass: got v=%b %h/%h want v=1 00000100/%h", out_valid, out_pc, out_inst, mkinst(32'h100)); end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) == 0);
            tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, out_valid, e_valid); end
            tests++; if (req_ready !== e_ready) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, req_ready, e_ready); end
            tests++; if (occupancy !== e_occ) begin fails++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", k, occupancy, e_occ); end
            if (e_valid) begin
                tests++; if (out_pc !== e_pc || out_inst !== mkinst(e_pc)) begin fails++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, e_pc, mkinst(e_pc)); end
            end else if (!e_kill && mq.size() == 0) begin
                tests++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin fails++; $display("FAIL rnd_idle[%0d]: got %h/%h want 0/0", k, out_pc, out_inst); end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_stall_fill();
        test_drain_wrap();
        test_flush();
        test_simul_wr_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
